bit_scan_engine: RTL

- Parametrised, multi-mode successor to the team's 4-bit ones-counter state machine.
- Accepts a WORD_SIZE-bit word on a start pulse and scans it serially, one bit per clock.
- Reports one of: population count, zero count, leading-zero count or trailing-zero count.
- Supports early termination, an abort input, and a start/busy/done handshake. Used by the normaliser and priority logic in the datapath.

---
 rtl/bit_scan_engine_pkg.sv | 21 ++
 rtl/bit_scan_engine_if.sv | 24 ++
 rtl/bit_scan_engine_datapath.sv | 81 ++++++++
 rtl/bit_scan_engine.sv | 121 ++++++++++++
 4 files changed

// File: rtl/bit_scan_engine_pkg.sv
// Shared encodings for the serial bit-scan engine: operating modes and
// controller state values.
package bit_scan_pkg;

    // Width of the controller state register; the fourth encoding is illegal.
    localparam int STATE_W = 2;

    typedef enum logic [1:0] {
        MODE_ONES  = 2'b00,
        MODE_ZEROS = 2'b01,
        MODE_LZ    = 2'b10,
        MODE_TZ    = 2'b11
    } scan_mode_e;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'b00,
        S_COUNT = 2'b01,
        S_DONE  = 2'b10
    } scan_state_e;

endpackage

// File: rtl/bit_scan_engine_if.sv
// Request/response bundle of the bit-scan engine. The requester drives
// start/mode/data/abort; the engine returns bit_count/busy/done.
interface bit_scan_engine_if #(
    parameter int WORD_SIZE    = 16,
    parameter int COUNTER_SIZE = 5
);
    logic                    start;
    logic [1:0]              mode;
    logic [WORD_SIZE-1:0]    data;
    logic                    abort;
    logic [COUNTER_SIZE-1:0] bit_count;
    logic                    busy;
    logic                    done;

    modport master (
        output start, mode, data, abort,
        input  bit_count, busy, done
    );

    modport slave (
        input  start, mode, data, abort,
        output bit_count, busy, done
    );
endinterface

// File: rtl/bit_scan_engine_datapath.sv
// Datapath of the bit-scan engine: operand shift register, remaining-bit
// counter and result counter. Leading-zero requests are turned into
// trailing-zero scans by bit-reversing the operand on load, and zero
// counting is turned into ones counting by inverting it.
module bit_scan_datapath
    import bit_scan_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int COUNTER_SIZE = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_s,
    input  logic                    clear_s,
    input  logic                    ones_step_s,
    input  logic                    zero_step_s,
    input  logic [1:0]              load_mode_s,
    input  logic [WORD_SIZE-1:0]    load_data_s,
    output logic [COUNTER_SIZE-1:0] bit_count_s,
    output logic                    temp_0_s,
    output logic                    temp_gt_1_s,
    output logic                    rem_zero_s
);

    localparam int REM_W = $clog2(WORD_SIZE + 1);

    logic [WORD_SIZE-1:0]    temp_r;
    logic [REM_W-1:0]        rem_r;
    logic [COUNTER_SIZE-1:0] bit_count_r;
    logic [WORD_SIZE-1:0]    load_word_s;

    function automatic logic [WORD_SIZE-1:0] reverse_bits(input logic [WORD_SIZE-1:0] w);
        logic [WORD_SIZE-1:0] r;
        for (int i = 0; i < WORD_SIZE; i++) begin
            r[i] = w[WORD_SIZE-1-i];
        end
        return r;
    endfunction

    // Select the operand form that reduces every mode to an LSB-first scan.
    always_comb begin
        load_word_s = load_data_s;
        case (load_mode_s)
            MODE_ONES:  load_word_s = load_data_s;
            MODE_ZEROS: load_word_s = ~load_data_s;
            MODE_LZ:    load_word_s = reverse_bits(load_data_s);
            MODE_TZ:    load_word_s = load_data_s;
            default:    load_word_s = load_data_s;
        endcase
    end

    // Load, clear, or advance the scan by one bit per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            temp_r      <= {WORD_SIZE{1'b0}};
            rem_r       <= {REM_W{1'b0}};
            bit_count_r <= {COUNTER_SIZE{1'b0}};
        end else if (load_s) begin
            temp_r      <= load_word_s;
            rem_r       <= REM_W'(WORD_SIZE);
            bit_count_r <= {COUNTER_SIZE{1'b0}};
        end else if (clear_s) begin
            bit_count_r <= {COUNTER_SIZE{1'b0}};
        end else if (ones_step_s) begin
            bit_count_r <= bit_count_r + COUNTER_SIZE'(temp_r[0]);
            temp_r      <= temp_r >> 1;
        end else if (zero_step_s) begin
            bit_count_r <= bit_count_r + COUNTER_SIZE'(1);
            temp_r      <= temp_r >> 1;
            rem_r       <= rem_r - REM_W'(1);
        end else begin
            bit_count_r <= bit_count_r;
        end
    end

    assign bit_count_s = bit_count_r;
    assign temp_0_s    = temp_r[0];
    assign temp_gt_1_s = |temp_r[WORD_SIZE-1:1];
    assign rem_zero_s  = (rem_r == {REM_W{1'b0}});

endmodule

// File: rtl/bit_scan_engine.sv
// Serial bit-scan engine: counts ones, zeros, leading zeros or trailing
// zeros of a word, one bit per clock, with start/busy/done handshake and
// abort. Holds the controller FSM; the datapath lives in bit_scan_datapath.
module bit_scan_engine
    import bit_scan_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int COUNTER_SIZE = 5
) (
    input  logic             clk,
    input  logic             reset,
    bit_scan_engine_if.slave bus
);

    if ((WORD_SIZE < 2) || (WORD_SIZE > 64)) begin : g_bad_word_size
        $fatal(1, "bit_scan_engine: WORD_SIZE must lie in 2..64");
    end

    if ((2 ** COUNTER_SIZE) <= WORD_SIZE) begin : g_bad_counter_size
        $fatal(1, "bit_scan_engine: 2**COUNTER_SIZE must exceed WORD_SIZE");
    end

    scan_state_e state_r;
    scan_state_e next_state_s;
    scan_mode_e  mode_r;
    logic        busy_r;
    logic        done_r;

    logic        load_s;
    logic        clear_s;
    logic        ones_step_s;
    logic        zero_step_s;
    logic        temp_0_s;
    logic        temp_gt_1_s;
    logic        rem_zero_s;
    logic [COUNTER_SIZE-1:0] bit_count_s;

    // Next-state and datapath strobes from the current state and scan status.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        clear_s      = 1'b0;
        ones_step_s  = 1'b0;
        zero_step_s  = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    load_s       = 1'b1;
                    next_state_s = S_COUNT;
                end else begin
                    next_state_s = state_r;
                end
            end
            S_COUNT: begin
                if (bus.abort) begin
                    clear_s      = 1'b1;
                    next_state_s = S_IDLE;
                end else if ((mode_r == MODE_ONES) || (mode_r == MODE_ZEROS)) begin
                    // Stop as soon as no set bits remain above the current one.
                    ones_step_s = 1'b1;
                    if (temp_gt_1_s) begin
                        next_state_s = S_COUNT;
                    end else begin
                        next_state_s = S_DONE;
                    end
                end else if (!temp_0_s && !rem_zero_s) begin
                    zero_step_s  = 1'b1;
                    next_state_s = S_COUNT;
                end else begin
                    next_state_s = S_DONE;
                end
            end
            default: begin
                clear_s      = 1'b1;
                next_state_s = S_IDLE;
            end
        endcase
    end

    // Controller state, latched mode and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            mode_r  <= MODE_ONES;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == S_COUNT);
            done_r  <= (next_state_s == S_DONE);
            if (load_s) begin
                mode_r <= scan_mode_e'(bus.mode);
            end else begin
                mode_r <= mode_r;
            end
        end
    end

    bit_scan_datapath #(
        .WORD_SIZE    (WORD_SIZE),
        .COUNTER_SIZE (COUNTER_SIZE)
    ) u_datapath (
        .clk         (clk),
        .reset       (reset),
        .load_s      (load_s),
        .clear_s     (clear_s),
        .ones_step_s (ones_step_s),
        .zero_step_s (zero_step_s),
        .load_mode_s (bus.mode),
        .load_data_s (bus.data),
        .bit_count_s (bit_count_s),
        .temp_0_s    (temp_0_s),
        .temp_gt_1_s (temp_gt_1_s),
        .rem_zero_s  (rem_zero_s)
    );

    assign bus.bit_count = bit_count_s;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule
